// File: rtl/branch_ctrl_if.sv
// Branch-control bus between decoder/fetch (master) and branch_ctrl (slave).
// BRANCH_CTRL_TRACE_EN adds the Taken_cnt trace output.
interface branch_ctrl_if #(
  parameter int unsigned PC_W   = 10,
  parameter int unsigned LUT_AW = 5
);
  logic              Instr_valid;
  logic [2:0]        Op;
  logic [LUT_AW-1:0] Lut_idx;
  logic              Cmp_result;
  logic [PC_W-1:0]   PC_in;
  logic              Lut_we;
  logic [LUT_AW-1:0] Lut_waddr;
  logic [PC_W-1:0]   Lut_wdata;
  logic              Branch_abs;
  logic              Flag_out;
  logic [PC_W-1:0]   Target;
  logic              Halt;
  logic              Done;
  logic              Stack_err;

`ifdef BRANCH_CTRL_TRACE_EN
  logic [15:0]       Taken_cnt;

  modport master (
    output Instr_valid, Op, Lut_idx, Cmp_result, PC_in, Lut_we, Lut_waddr, Lut_wdata,
    input  Branch_abs, Flag_out, Target, Halt, Done, Stack_err, Taken_cnt
  );

  modport slave (
    input  Instr_valid, Op, Lut_idx, Cmp_result, PC_in, Lut_we, Lut_waddr, Lut_wdata,
    output Branch_abs, Flag_out, Target, Halt, Done, Stack_err, Taken_cnt
  );
`else
  modport master (
    output Instr_valid, Op, Lut_idx, Cmp_result, PC_in, Lut_we, Lut_waddr, Lut_wdata,
    input  Branch_abs, Flag_out, Target, Halt, Done, Stack_err
  );

  modport slave (
    input  Instr_valid, Op, Lut_idx, Cmp_result, PC_in, Lut_we, Lut_waddr, Lut_wdata,
    output Branch_abs, Flag_out, Target, Halt, Done, Stack_err
  );
`endif
endinterface

// File: rtl/branch_ctrl.sv
// Control-flow resolver: condition flag, branch-target LUT, return-address stack, halt state.
// Optional saturating taken-branch counter when BRANCH_CTRL_TRACE_EN is defined.
module branch_ctrl #(
  parameter int unsigned PC_W      = 10,
  parameter int unsigned LUT_AW    = 5,
  parameter int unsigned RAS_DEPTH = 4
) (
  input logic           CLK,
  input logic           Init_n,
  branch_ctrl_if.slave  bus
);

  localparam int unsigned LutDepth = 2 ** LUT_AW;
  localparam int unsigned RasIdxW  = $clog2(RAS_DEPTH);
  localparam int unsigned CntW     = RasIdxW + 1;

  typedef enum logic [2:0] {
    OpNop  = 3'b000,
    OpSetf = 3'b001,
    OpBr   = 3'b010,
    OpJmp  = 3'b011,
    OpCall = 3'b100,
    OpRet  = 3'b101,
    OpHalt = 3'b110,
    OpRsvd = 3'b111
  } op_e;

  typedef enum logic {
    StRun,
    StHalted
  } state_e;

  state_e            state_q, state_d;
  logic              flag_q, flag_d;
  logic              stack_err_q;
  logic [PC_W-1:0]   lut_q [LutDepth];
  logic [PC_W-1:0]   ras_q [RAS_DEPTH];
  logic [CntW-1:0]   ras_cnt_q;

  op_e               op;
  logic              ras_full, ras_empty;
  logic [RasIdxW-1:0] ras_push_idx, ras_top_idx;
  logic [PC_W-1:0]   lut_rd;
  logic              push, pop, err_set;
  logic              branch_abs, flag_out, halt;
  logic [PC_W-1:0]   target;

  assign op           = op_e'(bus.Op);
  assign ras_full     = (ras_cnt_q == CntW'(RAS_DEPTH));
  assign ras_empty    = (ras_cnt_q == '0);
  assign ras_push_idx = ras_cnt_q[RasIdxW-1:0];
  // Depth is a power of two, so the low bits minus one wrap correctly when full.
  assign ras_top_idx  = ras_cnt_q[RasIdxW-1:0] - RasIdxW'(1);
  assign lut_rd       = lut_q[bus.Lut_idx];

  always_comb begin
    branch_abs = 1'b0;
    flag_out   = 1'b0;
    target     = '0;
    halt       = 1'b0;
    flag_d     = flag_q;
    push       = 1'b0;
    pop        = 1'b0;
    err_set    = 1'b0;
    state_d    = state_q;

    if (state_q == StHalted) begin
      halt = 1'b1;
    end else if (bus.Instr_valid) begin
      case (op)
        OpSetf: flag_d = bus.Cmp_result;
        OpBr: begin
          branch_abs = 1'b1;
          flag_out   = flag_q;
          target     = lut_rd;
        end
        OpJmp: begin
          branch_abs = 1'b1;
          flag_out   = 1'b1;
          target     = lut_rd;
        end
        OpCall: begin
          if (ras_full) begin
            halt    = 1'b1;
            err_set = 1'b1;
            state_d = StHalted;
          end else begin
            push       = 1'b1;
            branch_abs = 1'b1;
            flag_out   = 1'b1;
            target     = lut_rd;
          end
        end
        OpRet: begin
          if (ras_empty) begin
            halt    = 1'b1;
            err_set = 1'b1;
            state_d = StHalted;
          end else begin
            pop        = 1'b1;
            branch_abs = 1'b1;
            flag_out   = 1'b1;
            target     = ras_q[ras_top_idx];
          end
        end
        OpHalt: begin
          halt    = 1'b1;
          state_d = StHalted;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!Init_n) begin
      state_q     <= StRun;
      flag_q      <= 1'b0;
      stack_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flag_q  <= flag_d;
      if (err_set) begin
        stack_err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!Init_n) begin
      ras_cnt_q <= '0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        ras_q[i] <= '0;
      end
    end else if (push) begin
      ras_q[ras_push_idx] <= bus.PC_in + PC_W'(1);
      ras_cnt_q           <= ras_cnt_q + CntW'(1);
    end else if (pop) begin
      ras_cnt_q <= ras_cnt_q - CntW'(1);
    end
  end

  // LUT writes are accepted in either state; reads see the pre-edge contents.
  always_ff @(posedge CLK) begin
    if (!Init_n) begin
      for (int i = 0; i < int'(LutDepth); i++) begin
        lut_q[i] <= '0;
      end
    end else if (bus.Lut_we) begin
      lut_q[bus.Lut_waddr] <= bus.Lut_wdata;
    end
  end

`ifdef BRANCH_CTRL_TRACE_EN
  logic [15:0] taken_cnt_q;

  always_ff @(posedge CLK) begin
    if (!Init_n) begin
      taken_cnt_q <= '0;
    end else if (branch_abs && flag_out && (taken_cnt_q != 16'hFFFF)) begin
      taken_cnt_q <= taken_cnt_q + 16'd1;
    end
  end

  assign bus.Taken_cnt = taken_cnt_q;
`endif

  assign bus.Branch_abs = branch_abs;
  assign bus.Flag_out   = flag_out;
  assign bus.Target     = target;
  assign bus.Halt       = halt;
  assign bus.Done       = (state_q == StHalted);
  assign bus.Stack_err  = stack_err_q;

endmodule
